// File: rtl/i2c_slave_regs.sv
// I2C register-file responder. A 7-bit addressed slave that samples scl/sda
// with the system clock, supports register-pointer writes and combined
// (repeated-start) reads, and mirrors every bus write on a one-clk strobe.
//
// Handshake: there is no valid/ready pair on this block. wr_strobe is a
// one-clk qualifier for wr_addr/wr_data, and host_rdata is an unregistered
// read of the register file at host_raddr.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl,
  inout  wire                      sda,
  output logic                     busy,
  output logic                     wr_strobe,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [7:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0] host_raddr,
  output logic [7:0]               host_rdata
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t        state;
  logic [1:0]    scl_s;
  logic [1:0]    sda_s;
  logic          scl_d;
  logic          sda_d;
  logic          scl_q;
  logic          sda_q;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_det;
  logic          stop_det;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    byte_in;
  logic [AW-1:0] ptr;
  logic          rw;
  logic          oe;
  // Second half of an ACK slot: set once the slave has pulled sda low (or,
  // in RDATA_ACK, once the master has acknowledged).
  logic          ack_half;
  logic [7:0]    regs [DEPTH];

  // Open-drain output: only ever drive a low.
  assign sda        = oe ? 1'b0 : 1'bz;
  assign host_rdata = regs[host_raddr];

  assign scl_q     = scl_s[1];
  assign sda_q     = sda_s[1];
  assign scl_rise  = scl_q & ~scl_d;
  assign scl_fall  = ~scl_q & scl_d;
  assign start_det = scl_q & scl_d & sda_d & ~sda_q;
  assign stop_det  = scl_q & scl_d & ~sda_d & sda_q;
  assign byte_in   = {shift[6:0], sda_q};

  // Two-flop synchronisers plus one delay stage for edge detection. Reset to
  // the idle-bus level so leaving reset never looks like a bus condition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], scl};
      sda_s <= {sda_s[0], sda};
      scl_d <= scl_q;
      sda_d <= sda_q;
    end
  end

  // Protocol FSM with register file; START/STOP override bit handling.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      ptr       <= '0;
      rw        <= 1'b0;
      oe        <= 1'b0;
      ack_half  <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        // START or repeated START: pointer is kept for the combined read.
        state    <= ADDR;
        bit_cnt  <= 3'd0;
        shift    <= 8'h00;
        oe       <= 1'b0;
        ack_half <= 1'b0;
      end else if (stop_det) begin
        // STOP drops any partial byte without writing it.
        state    <= IDLE;
        bit_cnt  <= 3'd0;
        oe       <= 1'b0;
        ack_half <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  state <= ADDR_ACK;
                  busy  <= 1'b1;
                  rw    <= byte_in[0];
                end else begin
                  state <= IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_half) begin
                oe       <= 1'b1;
                ack_half <= 1'b1;
              end else begin
                ack_half <= 1'b0;
                bit_cnt  <= 3'd0;
                if (rw) begin
                  // Present the first read bit on the same falling edge.
                  state <= RDATA;
                  oe    <= ~regs[ptr][7];
                  shift <= {regs[ptr][6:0], 1'b0};
                end else begin
                  state <= REG;
                  oe    <= 1'b0;
                end
              end
            end
          end
          REG: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ptr   <= byte_in[AW-1:0];
                state <= REG_ACK;
              end
            end
          end
          REG_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_half) begin
                oe       <= 1'b1;
                ack_half <= 1'b1;
              end else begin
                oe       <= 1'b0;
                ack_half <= 1'b0;
                bit_cnt  <= 3'd0;
                state    <= WDATA;
              end
            end
          end
          WDATA: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                regs[ptr] <= byte_in;
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= byte_in;
                ptr       <= ptr + AW'(1);
                state     <= WDATA_ACK;
              end
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                oe       <= 1'b0;
                bit_cnt  <= 3'd0;
                ack_half <= 1'b0;
                state    <= RDATA_ACK;
              end else begin
                oe      <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise && !ack_half) begin
              if (sda_q) begin
                state <= IGNORE;
              end else begin
                ptr      <= ptr + AW'(1);
                ack_half <= 1'b1;
              end
            end else if (scl_fall && ack_half) begin
              ack_half <= 1'b0;
              bit_cnt  <= 3'd0;
              oe       <= ~regs[ptr][7];
              shift    <= {regs[ptr][6:0], 1'b0};
              state    <= RDATA;
            end
          end
          IGNORE: oe <= 1'b0;
          default: begin
            state <= IDLE;
            oe    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-banged I2C master drives the bus, a
// strobe monitor logs register writes, and a scoreboard compares them.
module tb_i2c_slave_regs;

  localparam int Q = 40;  // quarter SCL period in ns (SCL = 16 clk)

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       busy;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] host_raddr = 4'd0;
  logic [7:0] host_rdata;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .busy(busy),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_raddr(host_raddr), .host_rdata(host_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  logic [11:0] exp_q[$];

  // Monitor state, written only by the monitor process.
  int          strobe_cnt = 0;
  int          double_cnt = 0;
  int          low_cnt = 0;
  logic        prev_strobe = 1'b0;
  logic [11:0] strobe_log [64];

  // Log strobes and count clocks where the slave is pulling sda low.
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (strobe_cnt < 64) strobe_log[strobe_cnt] = {wr_addr, wr_data};
      strobe_cnt++;
    end
    if (wr_strobe && prev_strobe) double_cnt++;
    prev_strobe = wr_strobe;
    if (sda == 1'b0 && !m_low) low_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Compare strobes logged since 'base' against the expected queue.
  task automatic expect_strobes(input string name, input int base);
    int n;
    n = strobe_cnt - base;
    check({name, "_strobe_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < n && base + i < 64) check({name, "_strobe"}, strobe_log[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  // Driver tasks
  task automatic bus_start;
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop;
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q; #Q;
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #(2 * Q); scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  typedef struct {
    logic [7:0] ptr_byte;
    logic [7:0] data;
    logic [3:0] exp_idx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         base;

    vecs[0] = '{8'h03, 8'hA5, 4'd3};
    vecs[1] = '{8'h00, 8'h5A, 4'd0};
    vecs[2] = '{8'h0F, 8'hFF, 4'd15};
    vecs[3] = '{8'h17, 8'h81, 4'd7};   // pointer wraps modulo 16
    vecs[4] = '{8'h0A, 8'h3C, 4'd10};
    vecs[5] = '{8'h05, 8'h77, 4'd5};

    // Reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_sda", sda, 1);
    host_raddr = 4'd9; #1;
    check("rst_reg9", host_rdata, 8'h00);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single-byte writes from the vector table
    for (int v = 0; v < 6; v++) begin
      base = strobe_cnt;
      bus_start;
      write_byte(8'hA0, ack);          check("wr_ack_addr", ack, 0);
      write_byte(vecs[v].ptr_byte, ack); check("wr_ack_ptr", ack, 0);
      write_byte(vecs[v].data, ack);   check("wr_ack_data", ack, 0);
      check("wr_busy_active", busy, 1);
      bus_stop;
      check("wr_busy_after_stop", busy, 0);
      exp_q.push_back({vecs[v].exp_idx, vecs[v].data});
      expect_strobes("wr", base);
      host_raddr = vecs[v].exp_idx; #1;
      check("wr_host_rdata", host_rdata, vecs[v].data);
    end

    // Combined read: preload reg3/reg4 with a two-byte write, then read back
    base = strobe_cnt;
    bus_start;
    write_byte(8'hA0, ack); check("pre_ack_addr", ack, 0);
    write_byte(8'h03, ack); check("pre_ack_ptr", ack, 0);
    write_byte(8'hA5, ack); check("pre_ack_d0", ack, 0);
    write_byte(8'h3C, ack); check("pre_ack_d1", ack, 0);
    bus_stop;
    exp_q.push_back({4'd3, 8'hA5});
    exp_q.push_back({4'd4, 8'h3C});
    expect_strobes("pre", base);
    bus_start;
    write_byte(8'hA0, ack); check("rd_ack_addr_w", ack, 0);
    write_byte(8'h03, ack); check("rd_ack_ptr", ack, 0);
    bus_start;
    write_byte(8'hA1, ack); check("rd_ack_addr_r", ack, 0);
    read_byte(rd, 1'b0);    check("rd_byte0", rd, 8'hA5);
    read_byte(rd, 1'b1);    check("rd_byte1", rd, 8'h3C);
    check("rd_busy_active", busy, 1);
    bus_stop;
    check("rd_sda_released", sda, 1);
    check("rd_busy_after_stop", busy, 0);

    // Address mismatch: no ACK, no drive, no writes
    base = low_cnt;
    bus_start;
    write_byte(8'hB0, ack); check("mm_nack_addr", ack, 1);
    check("mm_busy", busy, 0);
    write_byte(8'h03, ack); check("mm_nack_ptr", ack, 1);
    write_byte(8'h11, ack); check("mm_nack_data", ack, 1);
    bus_stop;
    check("mm_no_drive", low_cnt - base, 0);
    expect_strobes("mm", strobe_cnt);
    host_raddr = 4'd3; #1;
    check("mm_reg3_kept", host_rdata, 8'hA5);

    // Auto-increment wrap 15 -> 0
    base = strobe_cnt;
    bus_start;
    write_byte(8'hA0, ack); check("wrap_ack_addr", ack, 0);
    write_byte(8'h0F, ack); check("wrap_ack_ptr", ack, 0);
    write_byte(8'h11, ack); check("wrap_ack_d0", ack, 0);
    write_byte(8'h22, ack); check("wrap_ack_d1", ack, 0);
    bus_stop;
    exp_q.push_back({4'd15, 8'h11});
    exp_q.push_back({4'd0, 8'h22});
    expect_strobes("wrap", base);
    host_raddr = 4'd15; #1; check("wrap_reg15", host_rdata, 8'h11);
    host_raddr = 4'd0;  #1; check("wrap_reg0", host_rdata, 8'h22);

    // Abort after four data bits: nothing written, next transfer ACKed
    base = strobe_cnt;
    bus_start;
    write_byte(8'hA0, ack); check("ab_ack_addr", ack, 0);
    write_byte(8'h05, ack); check("ab_ack_ptr", ack, 0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    bus_stop;
    expect_strobes("ab", base);
    host_raddr = 4'd5; #1; check("ab_reg5_kept", host_rdata, 8'h77);
    bus_start;
    write_byte(8'hA0, ack); check("ab_next_ack", ack, 0);
    bus_stop;
    check("ab_busy_after_stop", busy, 0);
    check("strobe_single_clk", double_cnt, 0);

    // Reset while the slave drives the address ACK low
    bus_start;
    for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);  // 0xA0
    m_low = 1'b0;
    #Q;
    check("rs_ack_driven", sda, 0);
    check("rs_busy_before", busy, 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rs_sda_released", sda, 1);
    check("rs_busy", busy, 0);
    @(negedge clk) rst = 1'b1;
    bus_stop;
    for (int r = 0; r < 16; r++) begin
      host_raddr = 4'(r); #1;
      check("rs_reg_cleared", host_rdata, 8'h00);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
